// File: rtl/nav_arb_if.sv
// rtl/nav_arb_if.sv - request/response bus between cmd_proc, maze_solve, nav_arb and navigate
interface nav_arb_if;
  logic               cmd_md;
  logic signed [11:0] dsrd_hdng_cmd;
  logic signed [11:0] dsrd_hdng_slv;
  logic               strt_hdng_cmd;
  logic               strt_hdng_slv;
  logic               strt_mv_cmd;
  logic               strt_mv_slv;
  logic               stp_lft_cmd;
  logic               stp_rght_cmd;
  logic               stp_lft_slv;
  logic               stp_rght_slv;
  logic               mv_cmplt;
  logic signed [11:0] dsrd_hdng;
  logic               strt_hdng;
  logic               strt_mv;
  logic               stp_lft;
  logic               stp_rght;
  logic               mv_cmplt_cmd;
  logic               mv_cmplt_slv;
  logic               nav_busy;
  logic               req_drop;
  logic               nav_fault;

  modport slave (
    input  cmd_md, dsrd_hdng_cmd, dsrd_hdng_slv, strt_hdng_cmd, strt_hdng_slv,
           strt_mv_cmd, strt_mv_slv, stp_lft_cmd, stp_rght_cmd, stp_lft_slv,
           stp_rght_slv, mv_cmplt,
    output dsrd_hdng, strt_hdng, strt_mv, stp_lft, stp_rght, mv_cmplt_cmd,
           mv_cmplt_slv, nav_busy, req_drop, nav_fault
  );

  modport master (
    output cmd_md, dsrd_hdng_cmd, dsrd_hdng_slv, strt_hdng_cmd, strt_hdng_slv,
           strt_mv_cmd, strt_mv_slv, stp_lft_cmd, stp_rght_cmd, stp_lft_slv,
           stp_rght_slv, mv_cmplt,
    input  dsrd_hdng, strt_hdng, strt_mv, stp_lft, stp_rght, mv_cmplt_cmd,
           mv_cmplt_slv, nav_busy, req_drop, nav_fault
  );
endinterface

// File: rtl/nav_arb.sv
// rtl/nav_arb.sv - owner arbitration, one-deep request queue and move watchdog in front of navigate
// Owner (1 = cmd_proc) only changes while idle; completions are routed back to the owner.
module nav_arb #(
  parameter bit FAST_SIM = 1'b1,
  parameter int WDOG_W   = FAST_SIM ? 16 : 26
) (
  input logic      clk,
  input logic      rst_n,
  nav_arb_if.slave nav
);
  typedef enum logic [1:0] {IDLE, BUSY, ISSUE} state_t;

  localparam logic [WDOG_W-1:0] WD_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic              owner;
  logic              slot_v, slot_v_n, slot_mv, slot_mv_n;
  logic              slot_sl, slot_sl_n, slot_sr, slot_sr_n;
  logic [11:0]       slot_hd, slot_hd_n;
  logic [WDOG_W-1:0] wdog;

  logic              own_h, own_m, own_sl, own_sr, oth_req;
  logic [11:0]       own_hd;
  logic              issue, iss_mv, iss_sl, iss_sr;
  logic [11:0]       iss_hd;
  logic              drop, cmplt_c, cmplt_s, fault_set;

  logic [11:0]       hdng_q;
  logic              sl_q, sr_q, sh_q, sm_q, cc_q, cs_q, drop_q, fault_q;

  assign own_h   = owner ? nav.strt_hdng_cmd : nav.strt_hdng_slv;
  assign own_m   = owner ? nav.strt_mv_cmd   : nav.strt_mv_slv;
  assign own_hd  = owner ? nav.dsrd_hdng_cmd : nav.dsrd_hdng_slv;
  assign own_sl  = owner ? nav.stp_lft_cmd   : nav.stp_lft_slv;
  assign own_sr  = owner ? nav.stp_rght_cmd  : nav.stp_rght_slv;
  assign oth_req = owner ? (nav.strt_hdng_slv | nav.strt_mv_slv)
                         : (nav.strt_hdng_cmd | nav.strt_mv_cmd);

  always_comb begin
    state_n   = state;
    slot_v_n  = slot_v;
    slot_mv_n = slot_mv;
    slot_hd_n = slot_hd;
    slot_sl_n = slot_sl;
    slot_sr_n = slot_sr;
    issue     = 1'b0;
    iss_mv    = 1'b0;
    iss_hd    = own_hd;
    iss_sl    = 1'b0;
    iss_sr    = 1'b0;
    drop      = oth_req;
    cmplt_c   = 1'b0;
    cmplt_s   = 1'b0;
    fault_set = 1'b0;

    // Heading wins a same-cycle tie; the move behind it goes to the slot.
    if (state == IDLE) begin
      if (own_h || own_m) begin
        issue   = 1'b1;
        iss_mv  = !own_h;
        iss_sl  = !own_h && own_sl;
        iss_sr  = !own_h && own_sr;
        state_n = BUSY;
        if (own_h && own_m) begin
          slot_v_n  = 1'b1;
          slot_mv_n = 1'b1;
          slot_hd_n = own_hd;
          slot_sl_n = own_sl;
          slot_sr_n = own_sr;
        end
      end
    end else if (own_h || own_m) begin
      if (slot_v) begin
        drop = 1'b1;
      end else begin
        slot_v_n  = 1'b1;
        slot_mv_n = !own_h;
        slot_hd_n = own_hd;
        slot_sl_n = !own_h && own_sl;
        slot_sr_n = !own_h && own_sr;
        if (own_h && own_m) drop = 1'b1;
      end
    end

    case (state)
      BUSY: begin
        // Completion takes priority over a same-cycle watchdog expiry.
        if (nav.mv_cmplt) begin
          cmplt_c = owner;
          cmplt_s = !owner;
          state_n = slot_v_n ? ISSUE : IDLE;
        end else if (&wdog) begin
          fault_set = 1'b1;
          slot_v_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      ISSUE: begin
        issue    = 1'b1;
        iss_mv   = slot_mv;
        iss_hd   = slot_hd;
        iss_sl   = slot_sl;
        iss_sr   = slot_sr;
        slot_v_n = 1'b0;
        state_n  = BUSY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b1;
      slot_v  <= 1'b0;
      slot_mv <= 1'b0;
      slot_hd <= '0;
      slot_sl <= 1'b0;
      slot_sr <= 1'b0;
      wdog    <= '0;
      hdng_q  <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      sh_q    <= 1'b0;
      sm_q    <= 1'b0;
      cc_q    <= 1'b0;
      cs_q    <= 1'b0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state == IDLE) owner <= nav.cmd_md;
      slot_v  <= slot_v_n;
      slot_mv <= slot_mv_n;
      slot_hd <= slot_hd_n;
      slot_sl <= slot_sl_n;
      slot_sr <= slot_sr_n;
      sh_q    <= issue && !iss_mv;
      sm_q    <= issue && iss_mv;
      if (issue) begin
        hdng_q <= iss_hd;
        sl_q   <= iss_sl;
        sr_q   <= iss_sr;
        wdog   <= '0;
      end else if (state == BUSY) begin
        wdog <= wdog + WD_ONE;
      end
      cc_q   <= cmplt_c;
      cs_q   <= cmplt_s;
      drop_q <= drop;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  assign nav.dsrd_hdng    = hdng_q;
  assign nav.strt_hdng    = sh_q;
  assign nav.strt_mv      = sm_q;
  assign nav.stp_lft      = sl_q;
  assign nav.stp_rght     = sr_q;
  assign nav.mv_cmplt_cmd = cc_q;
  assign nav.mv_cmplt_slv = cs_q;
  assign nav.nav_busy     = (state != IDLE);
  assign nav.req_drop     = drop_q;
  assign nav.nav_fault    = fault_q;
endmodule

// File: tb/tb_nav_arb.sv
// tb/tb_nav_arb.sv - bench for nav_arb: vector table, directed corner sequences, random vs reference model
module tb_nav_arb;
  localparam int WDOG_W  = 8;
  localparam int WD_TERM = (1 << WDOG_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cur_md = 1'b1;

  nav_arb_if nav();
  nav_arb #(.FAST_SIM(1'b1), .WDOG_W(WDOG_W)) dut (.clk(clk), .rst_n(rst_n), .nav(nav.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cmd_md;
    logic        hc, mc, hs, ms;
    logic [11:0] hd_c, hd_s;
    logic        slc, src, sls, srs;
    logic        cmplt;
  } in_t;

  typedef struct packed {
    logic        sh, sm;
    logic [11:0] hd;
    logic        sl, sr, cc, cs, busy, drop, fault;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  typedef struct {
    bit          mv;
    logic [11:0] hd;
    bit          sl;
    bit          sr;
  } req_t;

  int   checks = 0;
  int   errors = 0;

  req_t m_q[$];
  bit   m_owner, m_busy, m_issue;
  int   m_age;
  out_t m_out;

  function automatic in_t mk(input int md, input int hc, input int mc, input int hs, input int ms,
                             input int hd, input int sl, input int sr, input int cm);
    in_t i;
    i.cmd_md = md[0];
    i.hc = hc[0]; i.mc = mc[0]; i.hs = hs[0]; i.ms = ms[0];
    i.hd_c = hd[11:0]; i.hd_s = hd[11:0];
    i.slc = sl[0]; i.sls = sl[0]; i.src = sr[0]; i.srs = sr[0];
    i.cmplt = cm[0];
    return i;
  endfunction

  function automatic out_t mo(input int sh, input int sm, input int hd, input int sl, input int sr,
                              input int cc, input int cs, input int busy, input int drop, input int fault);
    out_t o;
    o.sh = sh[0]; o.sm = sm[0]; o.hd = hd[11:0]; o.sl = sl[0]; o.sr = sr[0];
    o.cc = cc[0]; o.cs = cs[0]; o.busy = busy[0]; o.drop = drop[0]; o.fault = fault[0];
    return o;
  endfunction

  function automatic in_t idle_in(input logic cm);
    in_t i = '0;
    i.cmd_md = cur_md;
    i.cmplt  = cm;
    return i;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.sh = nav.strt_hdng; o.sm = nav.strt_mv; o.hd = nav.dsrd_hdng;
    o.sl = nav.stp_lft; o.sr = nav.stp_rght; o.cc = nav.mv_cmplt_cmd; o.cs = nav.mv_cmplt_slv;
    o.busy = nav.nav_busy; o.drop = nav.req_drop; o.fault = nav.nav_fault;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("sh=%0b sm=%0b hd=%h sl=%0b sr=%0b cc=%0b cs=%0b busy=%0b drop=%0b fault=%0b",
                     o.sh, o.sm, o.hd, o.sl, o.sr, o.cc, o.cs, o.busy, o.drop, o.fault);
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {%s} want {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic apply(input in_t i);
    nav.cmd_md = i.cmd_md;
    nav.strt_hdng_cmd = i.hc; nav.strt_mv_cmd = i.mc;
    nav.strt_hdng_slv = i.hs; nav.strt_mv_slv = i.ms;
    nav.dsrd_hdng_cmd = i.hd_c; nav.dsrd_hdng_slv = i.hd_s;
    nav.stp_lft_cmd = i.slc; nav.stp_rght_cmd = i.src;
    nav.stp_lft_slv = i.sls; nav.stp_rght_slv = i.srs;
    nav.mv_cmplt = i.cmplt;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_owner = 1'b1;
    m_busy  = 1'b0;
    m_issue = 1'b0;
    m_age   = 0;
    m_out   = '0;
  endtask

  task automatic model_issue(input req_t r);
    m_out.sh = !r.mv;
    m_out.sm = r.mv;
    m_out.hd = r.hd;
    m_out.sl = r.mv ? r.sl : 1'b0;
    m_out.sr = r.mv ? r.sr : 1'b0;
    m_busy   = 1'b1;
    m_issue  = 1'b0;
    m_age    = 0;
  endtask

  // One clock edge of behaviour: requests form an ordered list, pending work is a queue of depth one.
  task automatic model_edge(input in_t i);
    req_t        reqs[$];
    req_t        r;
    bit          idle   = !m_busy;
    logic        own_h  = m_owner ? i.hc : i.hs;
    logic        own_m  = m_owner ? i.mc : i.ms;
    logic [11:0] own_hd = m_owner ? i.hd_c : i.hd_s;
    logic        own_sl = m_owner ? i.slc : i.sls;
    logic        own_sr = m_owner ? i.src : i.srs;
    m_out.sh = 1'b0; m_out.sm = 1'b0; m_out.cc = 1'b0; m_out.cs = 1'b0; m_out.drop = 1'b0;
    if (m_owner ? (i.hs | i.ms) : (i.hc | i.mc)) m_out.drop = 1'b1;
    if (own_h) reqs.push_back('{1'b0, own_hd, 1'b0, 1'b0});
    if (own_m) reqs.push_back('{1'b1, own_hd, own_sl, own_sr});
    if (idle) begin
      if (reqs.size() > 0) begin
        model_issue(reqs.pop_front());
        while (reqs.size() > 0) m_q.push_back(reqs.pop_front());
      end
      m_owner = i.cmd_md;
    end else begin
      while (reqs.size() > 0) begin
        r = reqs.pop_front();
        if (m_q.size() == 0) m_q.push_back(r);
        else m_out.drop = 1'b1;
      end
      if (m_issue) begin
        model_issue(m_q.pop_front());
      end else if (i.cmplt) begin
        if (m_owner) m_out.cc = 1'b1;
        else         m_out.cs = 1'b1;
        if (m_q.size() > 0) m_issue = 1'b1;
        else                m_busy  = 1'b0;
      end else if (m_age == WD_TERM) begin
        m_out.fault = 1'b1;
        m_q.delete();
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    m_out.busy = m_busy;
  endtask

  task automatic step(input in_t i);
    @(negedge clk);
    apply(i);
    @(posedge clk);
    model_edge(i);
    #1;
    chk("model", get_out(), m_out);
  endtask

  initial begin
    vec_t tbl[12];
    in_t  r;

    tbl[0]  = '{mk(1, 1, 0, 0, 0, 'h3FF, 0, 0, 0), mo(1, 0, 'h3FF, 0, 0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{mk(1, 0, 0, 0, 0, 'h3FF, 0, 0, 0), mo(0, 0, 'h3FF, 0, 0, 0, 0, 1, 0, 0)};
    tbl[2]  = '{mk(1, 0, 0, 0, 0, 'h3FF, 0, 0, 1), mo(0, 0, 'h3FF, 0, 0, 1, 0, 0, 0, 0)};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 'h3FF, 0, 0, 0), mo(0, 0, 'h3FF, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{mk(0, 0, 0, 1, 1, 'h000, 1, 0, 0), mo(1, 0, 'h000, 0, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{mk(0, 0, 1, 0, 0, 'h000, 0, 0, 0), mo(0, 0, 'h000, 0, 0, 0, 0, 1, 1, 0)};
    tbl[6]  = '{mk(0, 0, 0, 0, 1, 'h555, 0, 1, 0), mo(0, 0, 'h000, 0, 0, 0, 0, 1, 1, 0)};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 'h555, 0, 0, 1), mo(0, 0, 'h000, 0, 0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 'h000, 0, 0, 0), mo(0, 1, 'h000, 1, 0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 'h000, 0, 0, 0), mo(0, 0, 'h000, 1, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 'h000, 0, 0, 1), mo(0, 0, 'h000, 1, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 'h000, 0, 0, 0), mo(0, 0, 'h000, 1, 0, 0, 0, 0, 0, 0)};

    apply(idle_in(1'b0));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", get_out(), '0);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].in);
      chk($sformatf("tbl%0d", k), get_out(), tbl[k].exp);
    end

    // Ownership request made while busy is deferred until the block is idle again.
    cur_md = 1'b1;
    step(idle_in(1'b0));
    step(mk(1, 0, 1, 0, 0, 'h123, 0, 1, 0));
    chk1("defer_issue_mv", nav.strt_mv, 1'b1);
    chk1("defer_issue_rght", nav.stp_rght, 1'b1);
    cur_md = 1'b0;
    repeat (3) step(idle_in(1'b0));
    step(idle_in(1'b1));
    chk1("defer_cmplt_cmd", nav.mv_cmplt_cmd, 1'b1);
    chk1("defer_cmplt_slv", nav.mv_cmplt_slv, 1'b0);
    chk1("defer_busy_low", nav.nav_busy, 1'b0);
    step(mk(0, 0, 0, 1, 0, 'h0F0, 0, 0, 0));
    chk1("defer_old_owner_drop", nav.req_drop, 1'b1);
    chk1("defer_old_owner_noissue", nav.strt_hdng, 1'b0);
    step(mk(0, 0, 0, 1, 0, 'h0F0, 0, 0, 0));
    chk1("defer_new_owner_issue", nav.strt_hdng, 1'b1);
    step(idle_in(1'b1));
    chk1("defer_cmplt_to_slv", nav.mv_cmplt_slv, 1'b1);

    // Completion on the watchdog terminal cycle beats the fault.
    step(mk(0, 0, 0, 0, 1, 'h0AB, 0, 0, 0));
    repeat (WD_TERM) step(idle_in(1'b0));
    step(idle_in(1'b1));
    chk1("wd_race_no_fault", nav.nav_fault, 1'b0);
    chk1("wd_race_cmplt", nav.mv_cmplt_slv, 1'b1);

    // Withheld completion: fault one cycle after terminal count, pending move discarded.
    step(mk(0, 0, 0, 1, 1, 'h0CD, 1, 1, 0));
    repeat (WD_TERM) step(idle_in(1'b0));
    chk1("wd_before_fault", nav.nav_fault, 1'b0);
    chk1("wd_before_busy", nav.nav_busy, 1'b1);
    step(idle_in(1'b0));
    chk1("wd_fault_set", nav.nav_fault, 1'b1);
    chk1("wd_busy_low", nav.nav_busy, 1'b0);
    chk1("wd_no_cmplt", nav.mv_cmplt_slv, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(idle_in(1'b0));
      chk1("wd_slot_cleared", nav.strt_mv, 1'b0);
    end
    step(idle_in(1'b1));
    chk1("wd_idle_cmplt_ignored", nav.mv_cmplt_slv, 1'b0);

    // Asynchronous reset with a move pending behind a heading.
    step(mk(0, 0, 0, 1, 1, 'h0EE, 0, 1, 0));
    step(idle_in(1'b0));
    rst_n = 1'b0;
    #2;
    chk("reset_async", get_out(), '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_md = 1'b1;
    step(mk(1, 0, 1, 0, 0, 'h2A0, 1, 1, 0));
    chk("reset_first_issue", get_out(), mo(0, 1, 'h2A0, 1, 1, 0, 0, 1, 0, 0));
    step(idle_in(1'b1));

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) cur_md = ~cur_md;
      r.cmd_md = cur_md;
      r.hc = ($urandom_range(7) == 0);
      r.mc = ($urandom_range(7) == 0);
      r.hs = ($urandom_range(7) == 0);
      r.ms = ($urandom_range(7) == 0);
      r.hd_c = 12'($urandom);
      r.hd_s = 12'($urandom);
      r.slc = 1'($urandom);
      r.src = 1'($urandom);
      r.sls = 1'($urandom);
      r.srs = 1'($urandom);
      if (((c / 500) % 2) == 1) r.cmplt = ($urandom_range(399) == 0);
      else                      r.cmplt = ($urandom_range(7) == 0);
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nav_arb.md
# nav_arb

Arbiter and sequencer between the two command sources (`cmd_proc`, `maze_solve`) and the single `navigate` unit. It replaces the combinational `cmd_md` mux at the top level. Ownership of `navigate` changes only while it is idle, and the block buffers one request behind the one in flight. It routes `mv_cmplt` back to the owning requester only, and watchdogs every operation for a stuck move.

## Interface
- `FAST_SIM`, default 1: selects the watchdog length. 1 gives 2^16 clocks; 0 gives 2^26 clocks.
- `clk`  in  1  50MHz system clock
- `rst_n`  in  1  asynchronous active-low reset, from `reset_synch`
- `cmd_md`  in  1  1 = `cmd_proc` requests ownership, 0 = `maze_solve` requests ownership
- `dsrd_hdng_cmd`, `dsrd_hdng_slv`  in  12  signed desired heading from each source
- `strt_hdng_cmd`, `strt_hdng_slv`  in  1  one-cycle heading-start pulses
- `strt_mv_cmd`, `strt_mv_slv`  in  1  one-cycle move-start pulses
- `stp_lft_cmd`, `stp_rght_cmd`, `stp_lft_slv`, `stp_rght_slv`  in  1  stop qualifiers, sampled together with `strt_mv_*`
- `mv_cmplt`  in  1  completion pulse from `navigate`
- `dsrd_hdng`  out  12  registered heading to `navigate`/`IR_math`
- `strt_hdng`, `strt_mv`  out  1  registered one-cycle start pulses to `navigate`
- `stp_lft`, `stp_rght`  out  1  registered stop qualifiers, held for the whole move
- `mv_cmplt_cmd`, `mv_cmplt_slv`  out  1  per-owner completion pulses
- `nav_busy`  out  1  high from issue until completion or fault
- `req_drop`  out  1  one-cycle pulse when a request is discarded
- `nav_fault`  out  1  sticky watchdog flag; cleared only by reset

## Operation
- **Owner register:** reset value CMD. While the state is IDLE, the owner follows `cmd_md` every cycle. In any other state, changes on `cmd_md` wait until the state returns to IDLE.
- **Request sampling:** only the current owner's `strt_*` and `stp_*` inputs are sampled. A `strt_*` pulse from the non-owner is discarded and pulses `req_drop`.
- **Simultaneous pulses:** when `strt_hdng` and `strt_mv` arrive from the owner in the same cycle, the heading request issues first and the move request goes to the pending slot.
- **Pending slot:** holds one request (type, 12-bit heading, `stp_lft`, `stp_rght`) plus a valid bit.
  - An owner request arriving while the state is not IDLE fills the slot if it is empty.
  - If the slot is already full, the request is discarded and `req_drop` pulses.
- **States:**
  - IDLE: an owner request causes an issue and the state moves to BUSY.
  - BUSY: the block waits for `mv_cmplt`.
    - On `mv_cmplt` with the slot valid, the state moves to ISSUE.
    - On `mv_cmplt` with the slot empty, the state moves to IDLE.
  - ISSUE: the pending request is issued, the slot is cleared, and the state moves to BUSY.
- **Issue actions:** load `dsrd_hdng`, load `stp_lft`/`stp_rght`, and pulse the matching `strt_*` output for one cycle.
- **Heading issue:** `stp_lft` and `stp_rght` are driven to 0. `dsrd_hdng` keeps its last value until the next issue.
- **Move issue:** `dsrd_hdng` is reloaded with the heading sampled alongside the move request.
- **Completion routing:** `mv_cmplt` is routed to `mv_cmplt_cmd` or `mv_cmplt_slv` according to the owner. `mv_cmplt` received in IDLE or ISSUE is ignored.
- **Watchdog:** the counter clears on every issue and increments in BUSY. When it reaches all-ones (16 or 26 bits):
  - `nav_fault` is set;
  - the pending slot is cleared;
  - the state returns to IDLE;
  - no completion pulse is produced.
- **Completion versus timeout:** if `mv_cmplt` arrives in the same cycle as the watchdog terminal count, completion wins and no fault is raised.
- **Reset values:** all outputs 0, state IDLE, slot empty, counter 0, owner CMD.
- **Reset mid-operation:** asynchronous. It abandons the operation in flight without producing a completion pulse.

## Timing
- Owner request at cycle N while IDLE → `strt_*` high at N+1 only; `nav_busy` high from N+1.
- `dsrd_hdng` and `stp_*` are valid in the same cycle as the `strt_*` pulse.
- `mv_cmplt` at N → `mv_cmplt_<owner>` high at N+1 only.
  - With no pending request, `nav_busy` is low from N+1.
  - With a pending request, the next `strt_*` is high at N+2 and `nav_busy` stays high.
- A `cmd_md` change at N while IDLE → the owner updates at N+1. A request from the new owner at N+1 is accepted.
- `req_drop` pulses at N+1 for a request discarded at N.
- Watchdog terminal count at N → `nav_fault` and `nav_busy`=0 at N+1.

## Test plan
- **Simple heading:** `cmd_md`=1, `strt_hdng_cmd` with heading 12'h3FF at cycle 10 → `strt_hdng`=1 at cycle 11 with `dsrd_hdng`=12'h3FF. Then `mv_cmplt` at cycle 40 → `mv_cmplt_cmd` pulse at 41, `mv_cmplt_slv` stays 0, `nav_busy` falls at 41.
- **Queued move:** `strt_hdng_slv` (heading 12'h000) and `strt_mv_slv` with `stp_lft`=1 in the same cycle, `cmd_md`=0.
  - Expected: heading issues first.
  - After `mv_cmplt`, `strt_mv` issues 2 cycles after `mv_cmplt` with `stp_lft`=1.
- **Deferred ownership:** `cmd_md` toggles 1→0 while BUSY → the owner remains CMD, and the completion pulse goes to `mv_cmplt_cmd`. The owner becomes SLV on the cycle after `nav_busy` falls.
- **Drop cases:**
  - A non-owner `strt_mv` pulse → one `req_drop` pulse, no `strt_mv` output.
  - A third owner request while BUSY with the slot full → one `req_drop` pulse; the slot contents are unchanged.
- **Watchdog:** with `FAST_SIM`=1, issue a move and withhold `mv_cmplt` → `nav_fault` set exactly 65535 cycles after the issue (within 1 cycle), the slot is cleared, and no completion pulse appears. Repeat with `mv_cmplt` on the terminal cycle → no fault.
- **Reset mid-move:** assert `rst_n`=0 while BUSY with the slot valid → all outputs 0 immediately. After release, the first request issues normally.
